// File: rtl/minx_bus_pkg.sv
// Shared types for the minx CPU bus: command encodings, memory regions,
// region base addresses, the responder state enum and the address decoder.
package minx_bus_pkg;

   typedef enum logic [1:0] {
      BUS_COMMAND_IDLE = 2'd0,
      IRQ_READ         = 2'd1,
      MEM_WRITE        = 2'd2,
      MEM_READ         = 2'd3
   } bus_command_t;

   typedef enum logic [2:0] {
      REGION_BIOS,
      REGION_FB,
      REGION_RAM,
      REGION_IO,
      REGION_CART
   } region_t;

   typedef enum logic [2:0] {
      IDLE,
      MEM_ADDR,
      MEM_CAPT,
      CART,
      DONE
   } responder_state_t;

   localparam logic [23:0] BIOS_BASE = 24'h000000;
   localparam logic [23:0] FB_BASE   = 24'h001000;
   localparam logic [23:0] RAM_BASE  = 24'h001300;
   localparam logic [23:0] IO_BASE   = 24'h002000;
   localparam logic [23:0] CART_BASE = 24'h002100;

   // Everything from CART_BASE upward, across the full 24-bit space, is cartridge.
   function automatic region_t decode_region(input logic [23:0] address);
      if (address >= CART_BASE)
         return REGION_CART;
      else if (address >= IO_BASE)
         return REGION_IO;
      else if (address >= RAM_BASE)
         return REGION_RAM;
      else if (address >= FB_BASE)
         return REGION_FB;
      else
         return REGION_BIOS;
   endfunction

   // Offset within a region, computed in 12-bit arithmetic on the low address bits.
   function automatic logic [11:0] region_offset(input logic [23:0] address, input region_t region);
      logic [11:0] base;
      case (region)
         REGION_FB:   base = FB_BASE[11:0];
         REGION_RAM:  base = RAM_BASE[11:0];
         REGION_IO:   base = IO_BASE[11:0];
         REGION_CART: base = CART_BASE[11:0];
         default:     base = BIOS_BASE[11:0];
      endcase
      return address[11:0] - base;
   endfunction

endpackage

// File: rtl/minx_bus_responder_if.sv
// Bundle of CPU, memory and cartridge signals around the bus responder.
// The slave modport is the responder; master is everything around it.
interface minx_bus_responder_if;
   import minx_bus_pkg::*;

   logic [23:0]  cpu_address;
   bus_command_t cpu_bus_status;
   logic [7:0]   cpu_data_out;
   logic [7:0]   cpu_data_in;
   logic         cpu_ready;
   logic [7:0]   irq_vector;

   logic [7:0]   bios_q;
   logic [7:0]   fb_q;
   logic [7:0]   ram_q;
   logic [11:0]  mem_address;
   logic [7:0]   mem_data;
   logic         fb_we;
   logic         ram_we;

   logic         cart_req;
   logic         cart_we;
   logic [20:0]  cart_address;
   logic [7:0]   cart_wdata;
   logic [7:0]   cart_rdata;
   logic         cart_ack;
   logic         bus_error;

   modport slave (
      input  cpu_address, cpu_bus_status, cpu_data_out, irq_vector,
             bios_q, fb_q, ram_q, cart_rdata, cart_ack,
      output cpu_data_in, cpu_ready, mem_address, mem_data, fb_we, ram_we,
             cart_req, cart_we, cart_address, cart_wdata, bus_error
   );

   modport master (
      output cpu_address, cpu_bus_status, cpu_data_out, irq_vector,
             bios_q, fb_q, ram_q, cart_rdata, cart_ack,
      input  cpu_data_in, cpu_ready, mem_address, mem_data, fb_we, ram_we,
             cart_req, cart_we, cart_address, cart_wdata, bus_error
   );

endinterface

// File: rtl/minx_bus_responder.sv
// Memory-side responder for the minx CPU bus: decodes each transaction,
// drives the on-chip memories, forwards cartridge accesses over req/ack
// with a timeout, and returns read data with a one-cycle ready pulse.
module minx_bus_responder
   import minx_bus_pkg::*;
#(
   parameter int CART_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   minx_bus_responder_if.slave  bus
);

   responder_state_t state;
   region_t          region;
   region_t          req_region;
   logic [11:0]      req_offset;
   logic [7:0]       timer;

   // Decode the live request address so IDLE can dispatch on the sampling edge.
   always_comb begin
      req_region = decode_region(bus.cpu_address);
      req_offset = region_offset(bus.cpu_address, req_region);
   end

   // Transaction sequencer; every output is a register and the strobes default low each cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         region           <= REGION_BIOS;
         timer            <= '0;
         bus.cpu_data_in  <= '0;
         bus.cpu_ready    <= 1'b0;
         bus.mem_address  <= '0;
         bus.mem_data     <= '0;
         bus.fb_we        <= 1'b0;
         bus.ram_we       <= 1'b0;
         bus.cart_req     <= 1'b0;
         bus.cart_we      <= 1'b0;
         bus.cart_address <= '0;
         bus.cart_wdata   <= '0;
         bus.bus_error    <= 1'b0;
      end else begin
         bus.cpu_ready <= 1'b0;
         bus.fb_we     <= 1'b0;
         bus.ram_we    <= 1'b0;
         bus.bus_error <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cpu_bus_status != BUS_COMMAND_IDLE) begin
                  region          <= req_region;
                  bus.mem_address <= req_offset;
                  bus.mem_data    <= bus.cpu_data_out;
                  if (bus.cpu_bus_status == IRQ_READ) begin
                     bus.cpu_data_in <= bus.irq_vector;
                     bus.cpu_ready   <= 1'b1;
                     state           <= DONE;
                  end else if (req_region == REGION_CART) begin
                     bus.cart_req     <= 1'b1;
                     bus.cart_we      <= (bus.cpu_bus_status == MEM_WRITE);
                     bus.cart_address <= bus.cpu_address[20:0];
                     bus.cart_wdata   <= bus.cpu_data_out;
                     timer            <= '0;
                     state            <= CART;
                  end else if (bus.cpu_bus_status == MEM_WRITE) begin
                     bus.fb_we     <= (req_region == REGION_FB);
                     bus.ram_we    <= (req_region == REGION_RAM);
                     bus.cpu_ready <= 1'b1;
                     state         <= DONE;
                  end else if (req_region == REGION_IO) begin
                     bus.cpu_data_in <= 8'hFF;
                     bus.cpu_ready   <= 1'b1;
                     state           <= DONE;
                  end else begin
                     state <= MEM_ADDR;
                  end
               end
            end
            MEM_ADDR: begin
               state <= MEM_CAPT;
            end
            MEM_CAPT: begin
               case (region)
                  REGION_BIOS: bus.cpu_data_in <= bus.bios_q;
                  REGION_FB:   bus.cpu_data_in <= bus.fb_q;
                  REGION_RAM:  bus.cpu_data_in <= bus.ram_q;
                  default:     bus.cpu_data_in <= 8'hFF;
               endcase
               bus.cpu_ready <= 1'b1;
               state         <= DONE;
            end
            CART: begin
               if (bus.cart_ack) begin
                  bus.cart_req <= 1'b0;
                  bus.cart_we  <= 1'b0;
                  if (!bus.cart_we)
                     bus.cpu_data_in <= bus.cart_rdata;
                  bus.cpu_ready <= 1'b1;
                  state         <= DONE;
               end else if (timer == 8'(CART_TIMEOUT - 1)) begin
                  bus.cart_req    <= 1'b0;
                  bus.cart_we     <= 1'b0;
                  bus.cpu_data_in <= 8'hFF;
                  bus.bus_error   <= 1'b1;
                  bus.cpu_ready   <= 1'b1;
                  state           <= DONE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minx_bus_responder.sv
// Scoreboard bench for minx_bus_responder: one instance with the default
// cartridge timeout and one with a short timeout of 4 cycles.
module tb_minx_bus_responder;
   import minx_bus_pkg::*;

   typedef struct {
      string      name;
      logic [7:0] data;
      int         lat;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_compared = 0;
   int   n_mismatch = 0;
   exp_t sb[$];
   logic [7:0] ram_mem [4096];

   minx_bus_responder_if bus();
   minx_bus_responder_if bus_to();

   minx_bus_responder #(.CART_TIMEOUT(255)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   minx_bus_responder #(.CART_TIMEOUT(4)) dut_to (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_to.slave)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Synchronous-read memory models: writable RAM, patterned FB and BIOS.
   always @(posedge clk) begin
      if (bus.ram_we)
         ram_mem[bus.mem_address] <= bus.mem_data;
      bus.ram_q  <= ram_mem[bus.mem_address];
      bus.fb_q   <= bus.mem_address[7:0] ^ 8'h3C;
      bus.bios_q <= bus.mem_address[7:0] ^ 8'hA5;
   end

   task automatic push_exp(input string name, input logic [7:0] data, input int lat);
      exp_t e;
      e.name = name;
      e.data = data;
      e.lat  = lat;
      sb.push_back(e);
   endtask

   task automatic issue(input bus_command_t cmd, input logic [23:0] addr, input logic [7:0] wdata);
      bus.cpu_bus_status = cmd;
      bus.cpu_address    = addr;
      bus.cpu_data_out   = wdata;
   endtask

   task automatic wait_ready(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (bus.cpu_ready !== 1'b1 && lat < 300);
      if (bus.cpu_ready !== 1'b1)
         lat = -1;
   endtask

   task automatic end_request;
      bus.cpu_bus_status = BUS_COMMAND_IDLE;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      @(negedge clk);
      n_compared++;
      if (bus.cpu_data_in !== 8'h00) begin
         n_mismatch++;
         $display("[TB] FAIL reset_data_in: got %h, expected 00", bus.cpu_data_in);
      end
      n_compared++;
      if (bus.mem_address !== 12'h000 || bus.mem_data !== 8'h00) begin
         n_mismatch++;
         $display("[TB] FAIL reset_mem: got addr %h data %h, expected 000 00", bus.mem_address, bus.mem_data);
      end
      n_compared++;
      if ({bus.cpu_ready, bus.fb_we, bus.ram_we, bus.bus_error} !== 4'b0000) begin
         n_mismatch++;
         $display("[TB] FAIL reset_strobes: got %b, expected 0000",
                  {bus.cpu_ready, bus.fb_we, bus.ram_we, bus.bus_error});
      end
      n_compared++;
      if ({bus.cart_req, bus.cart_we, bus.cart_address, bus.cart_wdata} !== 31'd0) begin
         n_mismatch++;
         $display("[TB] FAIL reset_cart: got req %b we %b addr %h wdata %h, expected all zero",
                  bus.cart_req, bus.cart_we, bus.cart_address, bus.cart_wdata);
      end
      n_compared++;
      if (bus_to.cart_req !== 1'b0 || bus_to.cpu_ready !== 1'b0) begin
         n_mismatch++;
         $display("[TB] FAIL reset_second_instance: got req %b ready %b, expected 0 0",
                  bus_to.cart_req, bus_to.cpu_ready);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ram_write_read;
      exp_t e;
      int   lat;
      issue(MEM_WRITE, 24'h001305, 8'hA5);
      push_exp("ram_write", 8'h00, 1);
      wait_ready(lat);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus.cpu_data_in, e.lat, e.data);
      end
      n_compared++;
      if ({bus.ram_we, bus.fb_we} !== 2'b10 || bus.mem_address !== 12'h005 || bus.mem_data !== 8'hA5) begin
         n_mismatch++;
         $display("[TB] FAIL ram_write_strobe: got ram_we %b fb_we %b addr %h data %h, expected 1 0 005 a5",
                  bus.ram_we, bus.fb_we, bus.mem_address, bus.mem_data);
      end
      end_request;
      n_compared++;
      if (bus.ram_we !== 1'b0) begin
         n_mismatch++;
         $display("[TB] FAIL ram_we_one_cycle: got %b, expected 0", bus.ram_we);
      end
      issue(MEM_READ, 24'h001305, 8'h00);
      push_exp("ram_read", 8'hA5, 3);
      wait_ready(lat);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus.cpu_data_in, e.lat, e.data);
      end
      end_request;
   endtask

   task automatic test_fb_bios;
      exp_t e;
      int   lat;
      issue(MEM_READ, 24'h0012FF, 8'h00);
      push_exp("fb_read", 8'hC3, 3);
      wait_ready(lat);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data || bus.mem_address !== 12'h2FF) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h addr %h, expected lat %0d data %h addr 2ff",
                  e.name, lat, bus.cpu_data_in, bus.mem_address, e.lat, e.data);
      end
      end_request;
      issue(MEM_READ, 24'h000042, 8'h00);
      push_exp("bios_read", 8'hE7, 3);
      wait_ready(lat);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus.cpu_data_in, e.lat, e.data);
      end
      end_request;
      issue(MEM_WRITE, 24'h000010, 8'h99);
      push_exp("bios_write", 8'hE7, 1);
      wait_ready(lat);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data || {bus.fb_we, bus.ram_we} !== 2'b00) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h we %b, expected lat %0d data %h we 00",
                  e.name, lat, bus.cpu_data_in, {bus.fb_we, bus.ram_we}, e.lat, e.data);
      end
      end_request;
   endtask

   task automatic test_irq_io;
      exp_t e;
      int   lat;
      bus.irq_vector = 8'h1C;
      issue(IRQ_READ, 24'h000000, 8'h00);
      push_exp("irq_read", 8'h1C, 1);
      wait_ready(lat);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus.cpu_data_in, e.lat, e.data);
      end
      end_request;
      issue(MEM_READ, 24'h002080, 8'h00);
      push_exp("io_read", 8'hFF, 1);
      wait_ready(lat);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus.cpu_data_in, e.lat, e.data);
      end
      end_request;
      @(negedge clk);
      n_compared++;
      if (bus.cpu_data_in !== 8'hFF || bus.cpu_ready !== 1'b0) begin
         n_mismatch++;
         $display("[TB] FAIL data_hold: got data %h ready %b, expected ff 0", bus.cpu_data_in, bus.cpu_ready);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   lat;
      bus.irq_vector = 8'h1C;
      issue(IRQ_READ, 24'h000000, 8'h00);
      push_exp("b2b_first", 8'h1C, 1);
      push_exp("b2b_second", 8'h2D, 2);
      wait_ready(lat);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus.cpu_data_in, e.lat, e.data);
      end
      bus.irq_vector = 8'h2D;
      wait_ready(lat);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus.cpu_data_in, e.lat, e.data);
      end
      end_request;
   endtask

   task automatic test_cart_read;
      exp_t        e;
      int          lat;
      int          req_cycles;
      bit          acked;
      logic [20:0] seen_addr;
      logic        seen_we;
      lat        = 0;
      req_cycles = 0;
      acked      = 1'b0;
      seen_addr  = '0;
      seen_we    = 1'bx;
      bus.cart_rdata = 8'h3C;
      issue(MEM_READ, 24'h123456, 8'h00);
      push_exp("cart_read", 8'h3C, 6);
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus.cart_ack = 1'b0;
         if (bus.cart_req === 1'b1)
            req_cycles++;
         if (req_cycles == 5 && !acked) begin
            seen_addr    = bus.cart_address;
            seen_we      = bus.cart_we;
            bus.cart_ack = 1'b1;
            acked        = 1'b1;
         end
      end while (bus.cpu_ready !== 1'b1 && lat < 50);
      bus.cart_ack = 1'b0;
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus.cpu_data_in, e.lat, e.data);
      end
      n_compared++;
      if (req_cycles !== 5 || seen_addr !== 21'h123456 || seen_we !== 1'b0) begin
         n_mismatch++;
         $display("[TB] FAIL cart_req_shape: got cycles %0d addr %h we %b, expected 5 123456 0",
                  req_cycles, seen_addr, seen_we);
      end
      end_request;
   endtask

   task automatic test_timeout;
      exp_t e;
      int   lat;
      int   stray;
      logic err_seen;
      lat   = 0;
      stray = 0;
      bus_to.cpu_bus_status = MEM_READ;
      bus_to.cpu_address    = 24'h300000;
      push_exp("cart_timeout", 8'hFF, 5);
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (bus_to.cpu_ready !== 1'b1 && lat < 50);
      err_seen = bus_to.bus_error;
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus_to.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus_to.cpu_data_in, e.lat, e.data);
      end
      n_compared++;
      if (err_seen !== 1'b1 || bus_to.cart_req !== 1'b0) begin
         n_mismatch++;
         $display("[TB] FAIL timeout_error: got bus_error %b cart_req %b, expected 1 0", err_seen, bus_to.cart_req);
      end
      bus_to.cpu_bus_status = BUS_COMMAND_IDLE;
      bus_to.cart_rdata     = 8'h66;
      bus_to.cart_ack       = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         bus_to.cart_ack = 1'b0;
         if (bus_to.cpu_ready !== 1'b0 || bus_to.bus_error !== 1'b0)
            stray++;
      end
      n_compared++;
      if (stray !== 0 || bus_to.cpu_data_in !== 8'hFF) begin
         n_mismatch++;
         $display("[TB] FAIL late_ack_ignored: got %0d stray cycles data %h, expected 0 ff", stray, bus_to.cpu_data_in);
      end
      bus_to.irq_vector     = 8'h44;
      bus_to.cpu_bus_status = IRQ_READ;
      push_exp("after_timeout_irq", 8'h44, 1);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (bus_to.cpu_ready !== 1'b1 && lat < 50);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus_to.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus_to.cpu_data_in, e.lat, e.data);
      end
      bus_to.cpu_bus_status = BUS_COMMAND_IDLE;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_ack_at_expiry;
      exp_t e;
      int   lat;
      logic err_seen;
      lat = 0;
      bus_to.cart_rdata     = 8'h77;
      bus_to.cpu_bus_status = MEM_READ;
      bus_to.cpu_address    = 24'h002100;
      push_exp("ack_at_expiry", 8'h77, 5);
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus_to.cart_ack = (lat == 4);
      end while (bus_to.cpu_ready !== 1'b1 && lat < 50);
      bus_to.cart_ack = 1'b0;
      err_seen = bus_to.bus_error;
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus_to.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus_to.cpu_data_in, e.lat, e.data);
      end
      n_compared++;
      if (err_seen !== 1'b0) begin
         n_mismatch++;
         $display("[TB] FAIL ack_wins_no_error: got bus_error %b, expected 0", err_seen);
      end
      bus_to.cpu_bus_status = BUS_COMMAND_IDLE;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid_cart;
      exp_t e;
      int   lat;
      issue(MEM_WRITE, 24'h002100, 8'h11);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      n_compared++;
      if (bus.cart_req !== 1'b1 || bus.cart_we !== 1'b1 || bus.cart_wdata !== 8'h11) begin
         n_mismatch++;
         $display("[TB] FAIL cart_write_pending: got req %b we %b wdata %h, expected 1 1 11",
                  bus.cart_req, bus.cart_we, bus.cart_wdata);
      end
      reset = 1'b1;
      #1;
      n_compared++;
      if (bus.cart_req !== 1'b0 || bus.cpu_ready !== 1'b0 || bus.bus_error !== 1'b0) begin
         n_mismatch++;
         $display("[TB] FAIL reset_mid_cart: got req %b ready %b error %b, expected 0 0 0",
                  bus.cart_req, bus.cpu_ready, bus.bus_error);
      end
      bus.cpu_bus_status = BUS_COMMAND_IDLE;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.irq_vector = 8'h5A;
      issue(IRQ_READ, 24'h000000, 8'h00);
      push_exp("irq_after_reset", 8'h5A, 1);
      wait_ready(lat);
      e = sb.pop_front();
      n_compared++;
      if (lat !== e.lat || bus.cpu_data_in !== e.data) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got lat %0d data %h, expected lat %0d data %h", e.name, lat, bus.cpu_data_in, e.lat, e.data);
      end
      end_request;
   endtask

   // Test sequence.
   initial begin
      bus.cpu_bus_status    = BUS_COMMAND_IDLE;
      bus.cpu_address       = '0;
      bus.cpu_data_out      = '0;
      bus.irq_vector        = '0;
      bus.cart_rdata        = '0;
      bus.cart_ack          = 1'b0;
      bus_to.cpu_bus_status = BUS_COMMAND_IDLE;
      bus_to.cpu_address    = '0;
      bus_to.cpu_data_out   = '0;
      bus_to.irq_vector     = '0;
      bus_to.bios_q         = '0;
      bus_to.fb_q           = '0;
      bus_to.ram_q          = '0;
      bus_to.cart_rdata     = '0;
      bus_to.cart_ack       = 1'b0;
      test_reset;
      test_ram_write_read;
      test_fb_bios;
      test_irq_io;
      test_back_to_back;
      test_cart_read;
      test_timeout;
      test_ack_at_expiry;
      test_reset_mid_cart;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

   // Global time limit in case a stimulus loop stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/minx_bus_responder.md
# minx_bus_responder

Memory-side responder for the minx CPU bus. It decodes each CPU transaction, drives write strobes and addresses to the BIOS, framebuffer and work-RAM memories, and returns read data with a completion pulse. It forwards cartridge-space accesses over a req/ack handshake with a timeout. It sits between the `minx` core and its memories in `emu`, replacing ad-hoc top-level address decoding.

## Interface
Parameters:
- `CART_TIMEOUT`, 255: cycles to wait for `cart_ack` before aborting a cartridge access (1..255).

Ports:
- `clk` in 1: system clock (clk_sys); the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_address` in 24: transaction address; held stable until `cpu_ready`.
- `cpu_bus_status` in 2: command; encodings are the package constants IDLE, IRQ_READ, MEM_WRITE, MEM_READ.
- `cpu_data_out` in 8: write data from the CPU.
- `cpu_data_in` out 8: read data to the CPU; valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `irq_vector` in 8: byte returned for IRQ_READ.
- `bios_q`, `fb_q`, `ram_q` in 8 each: synchronous-read memory outputs.
- `mem_address` out 12: offset within the selected region.
- `mem_data` out 8: write data to the memories.
- `fb_we`, `ram_we` out 1: one-cycle write strobes.
- `cart_req` out 1: cartridge request, a level held until ack or timeout.
- `cart_we` out 1: cartridge request is a write.
- `cart_address` out 21: cartridge address, `cpu_address[20:0]`.
- `cart_wdata` out 8: cartridge write data.
- `cart_rdata` in 8: cartridge read data; valid when `cart_ack`=1.
- `cart_ack` in 1: one-cycle completion from the cartridge.
- `bus_error` out 1: one-cycle pulse on cartridge timeout.

## Operation
Address regions:
- BIOS: 0x0000–0x0FFF, read-only.
- FB: 0x1000–0x12FF.
- RAM: 0x1300–0x1FFF.
- IO: 0x2000–0x20FF, open bus.
- CART: 0x2100 and above.

Address and data rules:
- `mem_address` = `cpu_address[11:0]` minus the region base, in 12-bit arithmetic. FB therefore spans 0x000–0x2FF and RAM 0x000–0xCFF.

States: IDLE, MEM_ADDR, MEM_CAPT, CART, DONE.

- **IDLE:** a request is taken when `cpu_bus_status`≠IDLE. On the same edge, the responder registers the address, region, command and data.
  - IRQ_READ: `cpu_data_in`←`irq_vector`, `cpu_ready`←1, go to DONE.
  - MEM_WRITE to FB/RAM: matching `*_we`←1 for one cycle, `cpu_ready`←1, go to DONE.
  - MEM_WRITE to BIOS/IO: ignored, `cpu_ready`←1, go to DONE.
  - MEM_READ from IO: `cpu_data_in`←0xFF, `cpu_ready`←1, go to DONE.
  - MEM_READ from BIOS/FB/RAM: go to MEM_ADDR.
  - Any CART command: `cart_req`←1, timer←0, go to CART.
- **MEM_ADDR:** the memory samples `mem_address`; go to MEM_CAPT.
- **MEM_CAPT:** `cpu_data_in`←the selected `*_q`, `cpu_ready`←1, go to DONE.
- **CART:**
  - On `cart_ack`: `cart_req`←0; for a read, `cpu_data_in`←`cart_rdata`; `cpu_ready`←1; go to DONE.
  - When the timer reaches `CART_TIMEOUT` without ack: `cart_req`←0, `cpu_data_in`←0xFF, `bus_error`←1, `cpu_ready`←1, go to DONE.
  - Ack and expiry in the same cycle: ack wins, no `bus_error`.
- **DONE:** a one-cycle turnaround in which no request is sampled; go to IDLE. A request still held after DONE is treated as a new transaction.
- `cart_ack` outside CART is ignored.
- `cpu_data_in` holds its last value between transactions.

## Timing
- Latency is counted from the first cycle T in which a request is present while in IDLE.
  - IRQ_READ, writes and IO: `cpu_ready` at T+1.
  - BIOS/FB/RAM read: `cpu_ready` at T+3.
  - CART: `cpu_ready` one cycle after the `cart_ack` cycle, or at T+1+`CART_TIMEOUT` on timeout.
- Minimum request spacing is 2 cycles after `cpu_ready` (DONE, then IDLE).
- All outputs are registered.
- Reset values: `cpu_data_in`=0, `mem_address`=0, `mem_data`=0, `cart_address`=0, `cart_wdata`=0, and all strobes, `cart_req` and `cart_we`=0; state=IDLE.
- Reset mid-transaction: `cart_req` drops immediately, with no `cpu_ready` and no `bus_error`.

## Structure
- Package `minx_bus_pkg`:
  - `bus_command_t` with BUS_COMMAND_IDLE=0, IRQ_READ=1, MEM_WRITE=2, MEM_READ=3; `minx` and `emu` import it.
  - Region base constants.
  - `region_t`.
  - The responder state enum.
- No sub-module. The region decoder is a function in the package.

## Test plan
- MEM_WRITE 0x1305 data 0xA5, then MEM_READ 0x1305 with a RAM model: `ram_we` pulses at T+1 with `mem_address`=0x005; the read returns 0xA5 with `cpu_ready` at T+3.
- MEM_READ 0x12FF: FB selected, `mem_address`=0x2FF. MEM_WRITE 0x0010: no strobe, `cpu_ready` at T+1.
- IRQ_READ with `irq_vector`=0x1C: `cpu_data_in`=0x1C with `cpu_ready` at T+1. MEM_READ 0x2080: 0xFF.
- CART read 0x123456, ack after 5 cycles with `cart_rdata`=0x3C: `cart_address`=0x123456, `cart_req` high 5 cycles, returns 0x3C.
- `CART_TIMEOUT`=4, no ack: `bus_error` and `cpu_ready` at T+5 with 0xFF. A late ack is ignored.
- Reset asserted during CART: `cart_req`=0 immediately, no `cpu_ready`; the next request after release is served normally.
